montgomery_arbiter: RTL
=======================

Name: montgomery_arbiter

Overview:
- Round-robin arbiter that shares one Montgomery multiplier (q = 3329, 12-bit operands) between NUM_REQ independent requesters.
- Each requester hands over an operand pair with a valid/ready handshake. The arbiter issues a one-cycle enable to the multiplier and waits for its valid pulse. It then returns the 12-bit result to the owning requester as a one-cycle response pulse.
- Sits between the polynomial-arithmetic clients (NTT butterfly, basemul, scaling units) and the single shared multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 12, operand/result width.
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- req_valid  input  NUM_REQ  per-requester operand valid
- req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  input  NUM_REQ*DW  flattened operand a; requester i at [i*DW +: DW]
- req_b  input  NUM_REQ*DW  flattened operand b, same packing
- rsp_valid  output  NUM_REQ  one-hot, one-cycle result strobe to owner
- rsp_data  output  DW  result, shared by all requesters, qualified by rsp_valid
- mm_en  output  1  one-cycle start pulse to the multiplier
- mm_a  output  DW  registered operand a to the multiplier
- mm_b  output  DW  registered operand b to the multiplier
- mm_valid  input  1  multiplier result strobe
- mm_result  input  DW  multiplier result
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values: state=IDLE; all outputs 0; owner=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- Only one operation is in flight at a time. The multiplier is never re-enabled before its mm_valid returns.
- IDLE:
  - Grant g = first i with req_valid[i]=1, scanning last_grant+1, +2, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes there.
  - On the clock edge: latch req_a/req_b of g into mm_a/mm_b, owner<=g, go to ISSUE.
  - With no req_valid, stay in IDLE; req_ready=0.
- ISSUE: mm_en=1 for exactly this cycle; go to WAIT.
- WAIT:
  - mm_en=0.
  - On mm_valid=1: latch mm_result into rsp_data, go to RESP.
  - If mm_valid arrives in the same cycle as ISSUE→WAIT, it is ignored. It is only sampled while in WAIT.
- RESP:
  - rsp_valid[owner]=1 for one cycle; rsp_data holds the result.
  - last_grant<=owner; go to IDLE.
- rsp_data holds its last value outside RESP.
- No response backpressure: requesters must accept the rsp_valid pulse.
- Minimum request-to-response latency: accept edge + ISSUE + multiplier latency L + RESP, i.e. rsp_valid 3+L cycles after the accept cycle (L counted from mm_en high to mm_valid high).
- A requester may reassert req_valid in the cycle of its own RESP. The next IDLE cycle then arbitrates with round-robin fairness: owner has lowest priority.
- mm_valid outside WAIT is ignored and causes no state change.
- req_valid drop without handshake: no effect. Operands are captured only in the accept cycle.
- Reset mid-operation: immediate return to IDLE with reset values. Any in-flight multiplier result is later ignored because state != WAIT.
- Operands are passed unmodified. Range reduction (< q) is the requesters' responsibility.

Optional Feature:
- Macro: MONT_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without mm_valid, the arbiter goes to RESP with rsp_data=0.
  - Extra output port err (1 bit, reset 0) pulses for that one RESP cycle.
  - A sticky bit err_sticky (extra output) sets and clears only on reset.
- Without the macro: no counter, no err/err_sticky ports, WAIT lasts indefinitely.

Test Plan (bench multiplier stub: fixed L=3, returns a·b mod 3329):
- Single request: req_valid[0], a=5, b=7 → req_ready[0] same cycle; mm_en 1 cycle later with mm_a=5, mm_b=7; rsp_valid[0] with rsp_data=35 exactly 6 cycles after accept; busy high throughout.
- Wrap-around values: req 2, a=3328, b=3328 → rsp_valid[2], rsp_data=1.
- Contention: all four req_valid held continuously from reset → grants in order 0,1,2,3,0; each rsp_valid pulse only at its owner; no overlapping mm_en.
- Fairness: req 1 and req 3 continuously valid → alternating grants 1,3,1,3.
- Reset mid-op: assert rst_n=0 during WAIT, stub returns mm_valid afterwards → no rsp_valid; next request (a=2, b=9) returns 18.
- Timeout (MONT_ARB_TIMEOUT_EN, TIMEOUT=8, stub never answers) → rsp_valid[owner] after 8 WAIT cycles with rsp_data=0; err pulses; err_sticky stays 1.

Source files
------------

// File: rtl/montgomery_arbiter_if.sv
// Requester and multiplier signal bundle for montgomery_arbiter.
// err/err_sticky exist only when MONT_ARB_TIMEOUT_EN is defined.
interface montgomery_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 12
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_a;
    logic [NUM_REQ*DW-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_data;
    logic                  mm_en;
    logic [DW-1:0]         mm_a;
    logic [DW-1:0]         mm_b;
    logic                  mm_valid;
    logic [DW-1:0]         mm_result;
    logic                  busy;
`ifdef MONT_ARB_TIMEOUT_EN
    logic                  err;
    logic                  err_sticky;
`endif

    modport master (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  mm_valid,
        input  mm_result,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output mm_en,
        output mm_a,
        output mm_b,
`ifdef MONT_ARB_TIMEOUT_EN
        output err,
        output err_sticky,
`endif
        output busy
    );

    modport slave (
        output req_valid,
        output req_a,
        output req_b,
        output mm_valid,
        output mm_result,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  mm_en,
        input  mm_a,
        input  mm_b,
`ifdef MONT_ARB_TIMEOUT_EN
        input  err,
        input  err_sticky,
`endif
        input  busy
    );
endinterface

// File: rtl/montgomery_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier among NUM_REQ clients.
// Define MONT_ARB_TIMEOUT_EN to add the WAIT watchdog with err/err_sticky.
module montgomery_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 12,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    montgomery_arbiter_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("montgomery_arbiter: parameter out of range");
    end

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   cand;
    logic            found;
    logic [DW-1:0]   mm_a_q;
    logic [DW-1:0]   mm_b_q;
    logic [DW-1:0]   rsp_data_q;
    logic            mm_hit;
    logic [DW-1:0]   mm_res_q;
    logic [NUM_REQ-1:0] one;

    assign one = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Rotating priority: scan starts just after the previous owner.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

`ifdef MONT_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       wd_fire;
    logic       to_q;
    logic       err_sticky_q;

    assign wd_fire = (state == WAIT) && !mm_hit
                     && (wd_cnt == 8'(TIMEOUT - 1));
`endif

    always_comb begin
        state_n       = state;
        bus.req_ready = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    bus.req_ready = one << grant;
                    state_n       = ISSUE;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (mm_hit) begin
                    state_n = RESP;
                end
`ifdef MONT_ARB_TIMEOUT_EN
                else if (wd_fire) begin
                    state_n = RESP;
                end
`endif
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // mm_valid is registered on the way in and only while waiting, so a
    // strobe from an aborted or foreign operation can never complete one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            rsp_data_q <= '0;
            mm_hit     <= 1'b0;
            mm_res_q   <= '0;
        end else begin
            state  <= state_n;
            mm_hit <= (state == WAIT) && bus.mm_valid;
            if (state == WAIT && bus.mm_valid) begin
                mm_res_q <= bus.mm_result;
            end
            if (state == IDLE && found) begin
                mm_a_q <= bus.req_a[int'(grant)*DW +: DW];
                mm_b_q <= bus.req_b[int'(grant)*DW +: DW];
                owner  <= grant;
            end
            if (state == WAIT && mm_hit) begin
                rsp_data_q <= mm_res_q;
            end
`ifdef MONT_ARB_TIMEOUT_EN
            if (wd_fire) begin
                rsp_data_q <= '0;
            end
`endif
            if (state == RESP) begin
                last_grant <= owner;
            end
        end
    end

`ifdef MONT_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt       <= '0;
            to_q         <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wd_cnt <= '0;
                to_q   <= 1'b0;
            end else if (state == WAIT) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
            if (wd_fire) begin
                to_q         <= 1'b1;
                err_sticky_q <= 1'b1;
            end
        end
    end

    assign bus.err        = (state == RESP) && to_q;
    assign bus.err_sticky = err_sticky_q;
`endif

    assign bus.mm_en     = (state == ISSUE);
    assign bus.mm_a      = mm_a_q;
    assign bus.mm_b      = mm_b_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_valid = (state == RESP) ? (one << owner) : '0;
    assign bus.busy      = (state != IDLE);
endmodule
